// File: rtl/multi_tone_gen_pkg.sv
// Shared types and helpers for the multi-voice square-wave synthesiser.
// Optional feature macro: MULTI_TONE_GEN_DECAY_EN (per-voice amplitude decay).
package multi_tone_gen_pkg;

  typedef enum logic [1:0] {
    PAN_BOTH  = 2'b00,
    PAN_L     = 2'b01,
    PAN_R     = 2'b10,
    PAN_BOTH2 = 2'b11
  } pan_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PLAYING = 1'b1
  } voice_state_t;

  // Clamp a sign-extended value of in_w significant bits into the signed
  // range of out_w bits. The caller truncates the result to out_w bits.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] x,
    input int unsigned        in_w,
    input int unsigned        out_w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (in_w <= out_w) begin
      r = x;
    end else if (x > hi) begin
      r = hi;
    end else if (x < lo) begin
      r = lo;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_tone_gen_tone_voice.sv
// One square-wave voice: IDLE/PLAYING state, half-period counter, phase,
// amplitude and pan. Emits a signed contribution (+amp / -amp / 0).
// With MULTI_TONE_GEN_DECAY_EN defined, amplitude decays every DECAY_SAMPLES
// samples and the voice drops to IDLE once it reaches zero.
module tone_voice
  import multi_tone_gen_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PERIOD_W = 16
`ifdef MULTI_TONE_GEN_DECAY_EN
  , parameter int unsigned DECAY_SAMPLES = 4800
`endif
) (
  input  logic                     AUD_CLK,
  input  logic                     RESET,
  input  logic                     cmd_hit_i,
  input  logic                     cmd_on_i,
  input  logic [PERIOD_W-1:0]      cmd_period_i,
  input  logic [DATA_W-2:0]        cmd_amp_i,
  input  logic [1:0]               cmd_pan_i,
  output logic signed [DATA_W-1:0] contrib_o,
  output logic [1:0]               pan_o,
  output logic                     active_o
);

  localparam int unsigned AMP_W = DATA_W - 1;

  voice_state_t         state_q, state_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [AMP_W-1:0]     amp_q, amp_d;
  pan_t                 pan_q, pan_d;
  logic                 phase_q, phase_d;
  logic                 load;
  logic signed [DATA_W-1:0] amp_s;

`ifdef MULTI_TONE_GEN_DECAY_EN
  localparam int unsigned DCNT_W = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [AMP_W-1:0]  amp_step;
`endif

  // A note-on with zero period is treated as a note-off.
  assign load = cmd_hit_i && cmd_on_i && (cmd_period_i != '0);

  // Next-state: command has priority over tone advance for this voice.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    amp_d    = amp_q;
    pan_d    = pan_q;
    phase_d  = phase_q;
`ifdef MULTI_TONE_GEN_DECAY_EN
    dcnt_d   = dcnt_q;
    amp_step = '0;
`endif
    if (cmd_hit_i) begin
      if (load) begin
        state_d  = PLAYING;
        period_d = cmd_period_i;
        amp_d    = cmd_amp_i;
        pan_d    = pan_t'(cmd_pan_i);
        cnt_d    = '0;
        phase_d  = 1'b1;
`ifdef MULTI_TONE_GEN_DECAY_EN
        dcnt_d   = '0;
`endif
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == PLAYING) begin
      if (cnt_q == period_q - PERIOD_W'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
`ifdef MULTI_TONE_GEN_DECAY_EN
      if (dcnt_q == DCNT_W'(DECAY_SAMPLES - 1)) begin
        dcnt_d   = '0;
        amp_step = ((amp_q >> 3) == '0) ? AMP_W'(1) : (amp_q >> 3);
        if (amp_q <= amp_step) begin
          amp_d   = '0;
          state_d = IDLE;
        end else begin
          amp_d = amp_q - amp_step;
        end
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
`endif
    end
  end

  // Voice registers with synchronous reset.
  always_ff @(posedge AUD_CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      amp_q    <= '0;
      pan_q    <= PAN_BOTH;
      phase_q  <= 1'b0;
`ifdef MULTI_TONE_GEN_DECAY_EN
      dcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      amp_q    <= amp_d;
      pan_q    <= pan_d;
      phase_q  <= phase_d;
`ifdef MULTI_TONE_GEN_DECAY_EN
      dcnt_q   <= dcnt_d;
`endif
    end
  end

  assign amp_s = signed'({1'b0, amp_q});

  // Signed contribution from the current (pre-update) state.
  always_comb begin
    contrib_o = '0;
    if (state_q == PLAYING) begin
      contrib_o = phase_q ? amp_s : -amp_s;
    end
  end

  assign pan_o    = pan_q;
  assign active_o = (state_q == PLAYING);

endmodule

// File: rtl/multi_tone_gen.sv
// Multi-voice square-wave synthesiser: command decode, per-voice generators,
// saturating left/right mix and registered 16-bit codec samples.
// Optional feature macro: MULTI_TONE_GEN_DECAY_EN (forwarded to every voice).
module multi_tone_gen
  import multi_tone_gen_pkg::*;
#(
  parameter int unsigned NUM_VOICES    = 5,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned PERIOD_W      = 16,
  parameter int unsigned DECAY_SAMPLES = 4800,
  localparam int unsigned VIDX_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  AUD_CLK,
  input  logic                  RESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [VIDX_W-1:0]     cmd_voice,
  input  logic                  cmd_on,
  input  logic [PERIOD_W-1:0]   cmd_period,
  input  logic [DATA_W-2:0]     cmd_amp,
  input  logic [1:0]            cmd_pan,
  output logic [DATA_W-1:0]     LData,
  output logic [DATA_W-1:0]     RData,
  output logic [NUM_VOICES-1:0] voice_active
);

  localparam int unsigned ACC_W = DATA_W + $clog2(NUM_VOICES) + 1;

  if (NUM_VOICES < 1 || NUM_VOICES > 16 || DECAY_SAMPLES < 1) begin : g_bad_cfg
    $error("multi_tone_gen: NUM_VOICES must be 1..16 and DECAY_SAMPLES >= 1");
  end

  logic                     cmd_ready_q;
  logic                     accept;
  logic [NUM_VOICES-1:0]    hit;
  logic signed [DATA_W-1:0] contrib [NUM_VOICES];
  logic [1:0]               pan_v   [NUM_VOICES];
  logic signed [ACC_W-1:0]  sum_l, sum_r;
  logic [DATA_W-1:0]        ldata_d, rdata_d;
  logic [DATA_W-1:0]        ldata_q, rdata_q;

  assign accept = cmd_valid && cmd_ready_q;

  // Route an accepted command to its voice; out-of-range indices hit nothing.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      hit[i] = accept && (cmd_voice == VIDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    tone_voice #(
      .DATA_W   (DATA_W),
      .PERIOD_W (PERIOD_W)
`ifdef MULTI_TONE_GEN_DECAY_EN
      , .DECAY_SAMPLES (DECAY_SAMPLES)
`endif
    ) u_voice (
      .AUD_CLK      (AUD_CLK),
      .RESET        (RESET),
      .cmd_hit_i    (hit[g]),
      .cmd_on_i     (cmd_on),
      .cmd_period_i (cmd_period),
      .cmd_amp_i    (cmd_amp),
      .cmd_pan_i    (cmd_pan),
      .contrib_o    (contrib[g]),
      .pan_o        (pan_v[g]),
      .active_o     (voice_active[g])
    );
  end

  // Sum voice contributions per channel and clamp to the sample range.
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (pan_v[i] != PAN_R) sum_l = sum_l + ACC_W'(contrib[i]);
      if (pan_v[i] != PAN_L) sum_r = sum_r + ACC_W'(contrib[i]);
    end
    ldata_d = DATA_W'(saturate(64'(sum_l), ACC_W, DATA_W));
    rdata_d = DATA_W'(saturate(64'(sum_r), ACC_W, DATA_W));
  end

  // Output sample registers and command-port readiness.
  always_ff @(posedge AUD_CLK) begin
    if (RESET) begin
      ldata_q     <= '0;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      ldata_q     <= ldata_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= 1'b1;
    end
  end

  assign LData     = ldata_q;
  assign RData     = rdata_q;
  assign cmd_ready = cmd_ready_q;

endmodule
